// File: rtl/fetch_unit.sv
// Fetch stage in front of a synchronous instruction memory; presents {pc, instr} to decode one cycle after the address is issued.
// Under back-pressure the held PC is re-read so the memory output stays stable; a redirect overrides stall and squashes the presented instruction.
module fetch_unit #(
  parameter int addrWidth = 32,
  parameter int instrWidth = 32,
  parameter logic [addrWidth-1:0] resetPc = '0
) (
  input  logic                  clock,
  input  logic                  resetn,
  output logic [addrWidth-1:0]  imemAddr,
  input  logic [instrWidth-1:0] imemInstr,
  input  logic                  fetchEnable,
  input  logic                  redirectValid,
  input  logic [addrWidth-1:0]  redirectPc,
  output logic                  outValid,
  input  logic                  outReady,
  output logic [addrWidth-1:0]  outPc,
  output logic [instrWidth-1:0] outInstr
);

  logic [addrWidth-1:0] pc;
  logic [addrWidth-1:0] respPc;
  logic                 respValid;
  logic [addrWidth-1:0] tgt;
  logic                 stall;

  assign tgt   = {redirectPc[addrWidth-1:2], 2'b00};
  assign stall = respValid & ~redirectValid & ~outReady;

  // While stalled the memory is pointed back at the held PC so imemInstr does not change.
  always_comb begin
    imemAddr = pc;
    if (redirectValid) begin
      imemAddr = tgt;
    end else if (stall) begin
      imemAddr = respPc;
    end
  end

  assign outValid = respValid & ~redirectValid;
  assign outPc    = respPc;
  assign outInstr = imemInstr;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      pc        <= resetPc;
      respValid <= 1'b0;
      respPc    <= '0;
    end else if (redirectValid) begin
      respValid <= 1'b1;
      respPc    <= tgt;
      pc        <= tgt + addrWidth'(4);
    end else if (stall) begin
      pc        <= pc;
      respValid <= respValid;
      respPc    <= respPc;
    end else if (fetchEnable) begin
      respValid <= 1'b1;
      respPc    <= pc;
      pc        <= pc + addrWidth'(4);
    end else begin
      respValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit: a one-deep refill model predicts the accepted instruction stream into a scoreboard queue.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] imemAddr;
  logic [31:0] imemInstr;
  logic        fetchEnable = 1'b0;
  logic        redirectValid = 1'b0;
  logic [31:0] redirectPc = '0;
  logic        outValid;
  logic        outReady = 1'b0;
  logic [31:0] outPc;
  logic [31:0] outInstr;

  int checks = 0;
  int errors = 0;
  int transfers = 0;

  fetch_unit #(.addrWidth(32), .instrWidth(32), .resetPc(RESET_PC)) dut (
    .clock(clock), .resetn(resetn), .imemAddr(imemAddr), .imemInstr(imemInstr),
    .fetchEnable(fetchEnable), .redirectValid(redirectValid), .redirectPc(redirectPc),
    .outValid(outValid), .outReady(outReady), .outPc(outPc), .outInstr(outInstr)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return ((a >> 2) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Synchronous instruction memory: word at the sampled address appears the next cycle.
  always @(posedge clock) imemInstr <= memf(imemAddr);

  // Reference model: a one-entry buffer of fetched PCs, refilled from a sequential stream.
  logic [31:0] pending[$];
  logic [31:0] next_pc = RESET_PC;
  logic [63:0] exp_q[$];
  logic        exp_valid = 1'b0;
  logic [31:0] exp_addr = '0;
  bit          checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic cycle(input bit rn, input bit fe, input bit rv, input logic [31:0] rpc, input bit rdy);
    logic [31:0] tgt;
    bit          xfer;
    @(posedge clock);
    #1;
    resetn = rn; fetchEnable = fe; redirectValid = rv; redirectPc = rpc; outReady = rdy;
    tgt = {rpc[31:2], 2'b00};
    exp_valid = (pending.size() != 0) && !rv;
    xfer = exp_valid && rdy;
    if (rv) exp_addr = tgt;
    else if (pending.size() != 0 && !rdy) exp_addr = pending[0];
    else exp_addr = next_pc;
    if (xfer) exp_q.push_back({pending[0], memf(pending[0])});
    // Advance to the state seen after this edge.
    if (!rn) begin
      pending.delete();
      next_pc = RESET_PC;
    end else if (rv) begin
      pending.delete();
      pending.push_back(tgt);
      next_pc = tgt + 32'd4;
    end else begin
      if (xfer) void'(pending.pop_front());
      if (pending.size() == 0 && fe) begin
        pending.push_back(next_pc);
        next_pc = next_pc + 32'd4;
      end
    end
  endtask

  // Monitor: compares handshake-level outputs and pops the scoreboard on each transfer.
  always @(negedge clock) begin
    if (checking) begin
      logic [63:0] e;
      chk("outValid", {31'd0, outValid}, {31'd0, exp_valid});
      chk("imemAddr", imemAddr, exp_addr);
      chk("imemAddr_align", {30'd0, imemAddr[1:0]}, 32'd0);
      if (outValid === 1'b1 && outReady === 1'b1) begin
        transfers++;
        if (exp_q.size() == 0) begin
          chk("unexpected_transfer_pc", outPc, 32'hxxxx_xxxx);
        end else begin
          e = exp_q.pop_front();
          chk("outPc", outPc, e[63:32]);
          chk("outInstr", outInstr, e[31:0]);
        end
      end
    end
  end

  initial begin
    cycle(0, 1, 0, 0, 1);
    checking = 1'b1;
    cycle(0, 1, 0, 0, 1);
    // Free run across the PC wrap.
    repeat (5) cycle(1, 1, 0, 0, 1);
    // Back-pressure for three cycles then release.
    repeat (3) cycle(1, 1, 0, 0, 0);
    repeat (3) cycle(1, 1, 0, 0, 1);
    // Redirect with a concurrent ready, squashing the presented instruction.
    cycle(1, 1, 1, 32'h0000_0100, 1);
    repeat (3) cycle(1, 1, 0, 0, 1);
    // Redirect during a stall with fetch disabled; low address bits ignored.
    cycle(1, 1, 0, 0, 0);
    cycle(1, 0, 1, 32'h0000_0203, 0);
    cycle(1, 0, 0, 0, 0);
    repeat (3) cycle(1, 0, 0, 0, 1);
    repeat (3) cycle(1, 1, 0, 0, 1);
    // Fetch-enable drop and resume.
    cycle(1, 0, 0, 0, 1);
    repeat (2) cycle(1, 0, 0, 0, 1);
    repeat (3) cycle(1, 1, 0, 0, 1);
    // Mid-run reset for one edge.
    cycle(0, 1, 0, 0, 1);
    repeat (5) cycle(1, 1, 0, 0, 1);
    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rpc;
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
      cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0), rpc, ($urandom_range(0, 2) != 0));
    end
    repeat (3) cycle(1, 0, 0, 0, 1);
    @(negedge clock);
    #1;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    checks++;
    if (transfers < 500) begin
      errors++;
      $display("FAIL transfer_count: got %0d expected at least 500", transfers);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
